// File: rtl/tank_game_pkg.sv
// Shared constants and types for the tank game datapath.
// Sizes here set the default shape of the bullet slot arbiter.
package tank_game_pkg;

    localparam int N_TANK   = 4;
    localparam int N_BULLET = 4;
    localparam int TICK_HZ  = 4;
    localparam int OWNER_W  = 2;
    localparam int CD_W     = 4;
    localparam int LIFE_W   = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request
// found at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int   idx;
    logic found;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// Shares the bullet slots among all shooting tanks: latches shoot edges,
// applies cooldown and one-live-bullet rules, grants round-robin into the lowest free slot.
module bullet_slot_arbiter
    import tank_game_pkg::*;
#(
    parameter int N_REQ    = N_TANK,
    parameter int N_SLOT   = N_BULLET,
    parameter int COOLDOWN = 2,
    parameter int LIFETIME = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_4Hz,
    input  logic                      game_en,
    input  logic [N_REQ-1:0]          sht_req,
    input  logic [N_REQ-1:0]          tank_alive,
    input  logic [N_SLOT-1:0]         slot_done,
    output logic [N_REQ-1:0]          grant,
    output logic [N_SLOT-1:0]         slot_launch,
    output logic [N_SLOT-1:0]         slot_busy,
    output logic [OWNER_W*N_SLOT-1:0] slot_owner,
    output logic [N_REQ-1:0]          req_drop
);

    logic [2:0]         tick_sync;
    logic               tick;
    logic [N_REQ-1:0]   sht_q, sht_prev, req_edge;
    logic [N_REQ-1:0]   pending;
    logic [CD_W-1:0]    cd [N_REQ];
    logic [LIFE_W-1:0]  life [N_SLOT];
    logic [N_SLOT-1:0]  busy;
    logic [OWNER_W-1:0] owner [N_SLOT];
    logic [OWNER_W-1:0] rr_ptr;

    logic [N_REQ-1:0]   owns_busy, eligible, arb_req, gnt_vec, accept;
    logic [N_SLOT-1:0]  slot_oh;
    logic [OWNER_W-1:0] win_idx;
    logic               any_free, slot_found, do_grant;

    logic [N_REQ-1:0]   grant_q, drop_q;
    logic [N_SLOT-1:0]  launch_q;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    assign tick     = tick_sync[1] & ~tick_sync[2];
    assign req_edge = sht_q & ~sht_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync <= '0;
            sht_q     <= '0;
            sht_prev  <= '0;
        end else begin
            tick_sync <= {tick_sync[1:0], clk_4Hz};
            sht_q     <= sht_req;
            sht_prev  <= sht_q;
        end
    end

    // Free-slot and ownership views use registered busy only, so a slot released
    // this cycle becomes grantable on the next one.
    always_comb begin
        owns_busy  = '0;
        slot_oh    = '0;
        slot_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (busy[s] && owner[s] == OWNER_W'(i)) owns_busy[i] = 1'b1;
            end
            accept[i] = tank_alive[i] && (cd[i] == '0);
        end
        for (int s = 0; s < N_SLOT; s++) begin
            if (!busy[s] && !slot_found) begin
                slot_oh[s] = 1'b1;
                slot_found = 1'b1;
            end
        end
    end

    assign any_free = ~&busy;
    assign eligible = pending & tank_alive & ~owns_busy;
    assign arb_req  = (any_free && game_en) ? eligible : '0;
    assign do_grant = |gnt_vec;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (OWNER_W)
    ) u_rr_arbiter (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (gnt_vec)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vec[i]) win_idx = OWNER_W'(i);
        end
    end

    // Per-tank state: pending flag, cooldown counter, round-robin pointer, pulses.
    // NOTE: the small counter arrays are plain flops and are reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            rr_ptr  <= '0;
            grant_q <= '0;
            drop_q  <= '0;
            for (int i = 0; i < N_REQ; i++) cd[i] <= '0;
        end else if (!game_en) begin
            pending <= '0;
            rr_ptr  <= '0;
            grant_q <= '0;
            drop_q  <= '0;
            for (int i = 0; i < N_REQ; i++) cd[i] <= '0;
        end else begin
            grant_q <= gnt_vec;
            drop_q  <= req_edge & ~pending & ~accept;
            if (do_grant) begin
                rr_ptr <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_vec[i] || !tank_alive[i]) begin
                    pending[i] <= 1'b0;
                end else if (req_edge[i] && accept[i]) begin
                    pending[i] <= 1'b1;
                end
                // A grant reloads the cooldown even when a tick lands in the same cycle.
                if (gnt_vec[i]) begin
                    cd[i] <= CD_W'(COOLDOWN);
                end else if (tick && cd[i] != '0) begin
                    cd[i] <= cd[i] - 1'b1;
                end
            end
        end
    end

    // Slot table: load on grant, retire on slot_done or lifetime expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            launch_q <= '0;
            for (int s = 0; s < N_SLOT; s++) begin
                owner[s] <= '0;
                life[s]  <= '0;
            end
        end else if (!game_en) begin
            busy     <= '0;
            launch_q <= '0;
            for (int s = 0; s < N_SLOT; s++) begin
                owner[s] <= '0;
                life[s]  <= '0;
            end
        end else begin
            launch_q <= do_grant ? slot_oh : '0;
            for (int s = 0; s < N_SLOT; s++) begin
                if (do_grant && slot_oh[s]) begin
                    busy[s]  <= 1'b1;
                    owner[s] <= win_idx;
                    life[s]  <= LIFE_W'(LIFETIME);
                end else if (busy[s]) begin
                    if (slot_done[s]) begin
                        busy[s] <= 1'b0;
                        life[s] <= '0;
                    end else if (tick) begin
                        if (life[s] <= LIFE_W'(1)) begin
                            busy[s] <= 1'b0;
                            life[s] <= '0;
                        end else begin
                            life[s] <= life[s] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        slot_owner = '0;
        for (int s = 0; s < N_SLOT; s++) slot_owner[s*OWNER_W +: OWNER_W] = owner[s];
    end

    assign grant       = grant_q;
    assign slot_launch = launch_q;
    assign slot_busy   = busy;
    assign req_drop    = drop_q;

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Scoreboard bench for bullet_slot_arbiter: directed stimulus pushes expected
// grant/launch/drop events, a forked monitor pops and compares each DUT event.
module tb_bullet_slot_arbiter;

    logic       clk;
    logic       rst_n;
    logic       clk_4Hz;
    logic       game_en;
    logic [3:0] sht_req;
    logic [3:0] tank_alive;
    logic [3:0] slot_done;
    logic [3:0] grant;
    logic [3:0] slot_launch;
    logic [3:0] slot_busy;
    logic [7:0] slot_owner;
    logic [3:0] req_drop;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] l;
        logic [3:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    bullet_slot_arbiter #(
        .N_REQ    (4),
        .N_SLOT   (4),
        .COOLDOWN (2),
        .LIFETIME (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_4Hz     (clk_4Hz),
        .game_en     (game_en),
        .sht_req     (sht_req),
        .tank_alive  (tank_alive),
        .slot_done   (slot_done),
        .grant       (grant),
        .slot_launch (slot_launch),
        .slot_busy   (slot_busy),
        .slot_owner  (slot_owner),
        .req_drop    (req_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [3:0] g, input logic [3:0] l, input logic [3:0] d);
        ev_t e;
        e.g = g;
        e.l = l;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic fire(input logic [3:0] m);
        sht_req = sht_req | m;
        cyc(1);
        sht_req = sht_req & ~m;
    endtask

    task automatic pulse_done(input logic [3:0] m);
        slot_done = m;
        cyc(1);
        slot_done = '0;
    endtask

    task automatic tick();
        clk_4Hz = 1'b1;
        cyc(4);
        clk_4Hz = 1'b0;
        cyc(4);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (grant | slot_launch | req_drop) != '0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got grant=%b launch=%b drop=%b, want none",
                             grant, slot_launch, req_drop);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_grant", 32'(grant), 32'(e.g));
                    check("ev_launch", 32'(slot_launch), 32'(e.l));
                    check("ev_drop", 32'(req_drop), 32'(e.d));
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_4Hz    = 1'b0;
        game_en    = 1'b0;
        sht_req    = '0;
        tank_alive = '0;
        slot_done  = '0;
        fork
            monitor();
        join_none
        cyc(3);
        check("rst_grant", 32'(grant), 0);
        check("rst_launch", 32'(slot_launch), 0);
        check("rst_busy", 32'(slot_busy), 0);
        check("rst_owner", 32'(slot_owner), 0);
        check("rst_drop", 32'(req_drop), 0);

        rst_n      = 1'b1;
        game_en    = 1'b1;
        tank_alive = 4'hF;
        cyc(2);

        // First shot from the player tank lands in slot 0.
        expect_ev(4'b0001, 4'b0001, 4'b0000);
        fire(4'b0001);
        wait_drain(10);
        check("first_busy", 32'(slot_busy), 32'h1);
        check("first_owner0", 32'(slot_owner[1:0]), 0);

        // One tick later the cooldown is still 1: the edge is dropped.
        tick();
        expect_ev(4'b0000, 4'b0000, 4'b0001);
        fire(4'b0001);
        wait_drain(10);

        // Cooldown expired but bullet still live: held until slot_done, then granted.
        tick();
        fire(4'b0001);
        cyc(6);
        check("held_busy", 32'(slot_busy), 32'h1);
        expect_ev(4'b0001, 4'b0001, 4'b0000);
        pulse_done(4'b0001);
        check("done_clears_busy", 32'(slot_busy), 0);
        cyc(1);
        check("regrant_next_clk", 32'(grant), 32'h1);
        wait_drain(5);
        check("regrant_busy", 32'(slot_busy), 32'h1);

        // Flush, then four simultaneous edges fill slots 0..3 in order.
        game_en = 1'b0;
        cyc(1);
        check("flush_busy", 32'(slot_busy), 0);
        game_en = 1'b1;
        for (int i = 0; i < 4; i++) expect_ev(4'(1 << i), 4'(1 << i), 4'b0000);
        fire(4'hF);
        wait_drain(12);
        check("all_busy", 32'(slot_busy), 32'hF);
        check("all_owner", 32'(slot_owner), 32'hE4);

        // Fifth request waits; freeing another tank's slot does not help tank 0.
        tick();
        tick();
        fire(4'b0001);
        pulse_done(4'b0100);
        cyc(5);
        check("fifth_wait_busy", 32'(slot_busy), 32'hB);
        expect_ev(4'b0001, 4'b0001, 4'b0000);
        pulse_done(4'b0001);
        wait_drain(5);
        check("fifth_busy", 32'(slot_busy), 32'hB);
        check("fifth_owner0", 32'(slot_owner[1:0]), 0);

        // Round robin from pointer 2 with tanks 1 and 3 pending: 3 first, then 1.
        game_en = 1'b0;
        cyc(1);
        game_en = 1'b1;
        expect_ev(4'b0010, 4'b0001, 4'b0000);
        fire(4'b0010);
        wait_drain(10);
        pulse_done(4'b0001);
        tick();
        tick();
        expect_ev(4'b1000, 4'b0001, 4'b0000);
        expect_ev(4'b0010, 4'b0010, 4'b0000);
        fire(4'b1010);
        wait_drain(10);
        check("rr_owner", 32'(slot_owner[3:0]), 32'h7);

        // Lifetime: both live slots retire exactly on the 20th tick.
        for (int t = 0; t < 19; t++) tick();
        check("life19_busy", 32'(slot_busy), 32'h3);
        clk_4Hz = 1'b1;
        cyc(2);
        check("life20_before", 32'(slot_busy), 32'h3);
        cyc(1);
        check("life20_after", 32'(slot_busy), 0);
        clk_4Hz = 1'b0;
        cyc(4);

        // Pending tank dies before its grant: pending cleared, no grant later.
        fire(4'b0010);
        cyc(1);
        tank_alive = 4'b1101;
        cyc(3);
        tank_alive = 4'hF;
        cyc(6);
        check("dead_busy", 32'(slot_busy), 0);

        // Edge from a dead tank is dropped.
        tank_alive = 4'b1011;
        expect_ev(4'b0000, 4'b0000, 4'b0100);
        fire(4'b0100);
        wait_drain(10);
        tank_alive = 4'hF;

        // Three live slots, then game_en low clears everything silently.
        expect_ev(4'b0100, 4'b0001, 4'b0000);
        expect_ev(4'b0001, 4'b0010, 4'b0000);
        expect_ev(4'b0010, 4'b0100, 4'b0000);
        fire(4'b0111);
        wait_drain(12);
        check("three_busy", 32'(slot_busy), 32'h7);
        check("three_owner", 32'(slot_owner), 32'h12);
        game_en = 1'b0;
        cyc(1);
        check("disable_busy", 32'(slot_busy), 0);
        check("disable_owner", 32'(slot_owner), 0);
        fire(4'b1000);
        cyc(4);
        game_en = 1'b1;
        cyc(3);

        // Async reset mid-operation drops the pending request; first edge after release grants.
        expect_ev(4'b0001, 4'b0001, 4'b0000);
        fire(4'b0001);
        wait_drain(10);
        fire(4'b0010);
        cyc(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(slot_busy), 0);
        check("async_grant", 32'(grant), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_ev(4'b0001, 4'b0001, 4'b0000);
        fire(4'b0001);
        cyc(2);
        check("post_reset_grant", 32'(grant), 32'h1);
        wait_drain(5);
        cyc(4);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
